// File: rtl/key_sw_io_device_pkg.sv
// Shared I/O address map and control-register layout for memory-mapped devices.
// Used by the processor top and every device responder on the data bus.
package key_sw_io_device_pkg;

  localparam int DBITS = 32;

  localparam logic [DBITS-1:0] ADDRHEX   = 32'hF000_0000;
  localparam logic [DBITS-1:0] ADDRLEDR  = 32'hF000_0004;
  localparam logic [DBITS-1:0] ADDRLEDG  = 32'hF000_0008;
  localparam logic [DBITS-1:0] ADDRKEY   = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDRSW    = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDRKCTRL = 32'hF000_0110;
  localparam logic [DBITS-1:0] ADDRSCTRL = 32'hF000_0114;

  localparam int CTRL_READY   = 0;
  localparam int CTRL_OVERRUN = 2;
  localparam int CTRL_IE      = 4;

  typedef struct packed {
    logic ready;
    logic overrun;
    logic ie;
  } dev_status_t;

  function automatic logic [DBITS-1:0] ctrl_word(dev_status_t s);
    logic [DBITS-1:0] w;
    w               = '0;
    w[CTRL_READY]   = s.ready;
    w[CTRL_OVERRUN] = s.overrun;
    w[CTRL_IE]      = s.ie;
    return w;
  endfunction

endpackage

// File: rtl/key_sw_io_device_if.sv
// Processor data-bus slice seen by a memory-mapped device: the CPU is master,
// the device answers loads combinationally and takes stores at the clock edge.
interface key_sw_io_device_if;
  import key_sw_io_device_pkg::*;

  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic [DBITS-1:0] rdata;
  logic             hit;

  modport master (output addr, wdata, we, re, input rdata, hit);
  modport slave  (input addr, wdata, we, re, output rdata, hit);

endinterface

// File: rtl/key_sw_io_device_io_debounce.sv
// Two-flop synchroniser plus stability counter; the stable value updates only
// after DEBCYCLES consistent cycles and a one-cycle change pulse accompanies it.
module io_debounce #(
  parameter int WIDTH     = 4,
  parameter int DEBCYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] value_o,
  output logic             change_o
);

  localparam int CW = $clog2(DEBCYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The pulse is combinational so status registers update on the same edge as
  // the stable value; loading one step early makes the latency exactly 2+DEBCYCLES.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    change_o = 1'b0;
    if (sync2_q == stable_q || sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBCYCLES - 2)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      change_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign value_o = stable_q;

endmodule

// File: rtl/key_sw_io_device.sv
// KEY/SW bus responder: debounced data registers, sticky Ready/Overrun status,
// per-device interrupt enable and one registered level interrupt request.
module key_sw_io_device
  import key_sw_io_device_pkg::*;
#(
  parameter int DEBCYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          KEY,
  input  logic [9:0]          SW,
  key_sw_io_device_if.slave   bus,
  output logic                irq
);

  logic [3:0]       key_val;
  logic [9:0]       sw_val;
  logic [1:0]       ev;
  logic [1:0]       irq_src;
  logic [DBITS-1:0] ctrl_rd [2];
  logic             irq_q;
  logic             wdata_unused;

  // Buttons are active-low; invert so a pressed key reads as 1.
  io_debounce #(.WIDTH(4), .DEBCYCLES(DEBCYCLES)) u_key_deb (
    .clk(clk), .reset(reset), .din_i(~KEY), .value_o(key_val), .change_o(ev[0])
  );

  io_debounce #(.WIDTH(10), .DEBCYCLES(DEBCYCLES)) u_sw_deb (
    .clk(clk), .reset(reset), .din_i(SW), .value_o(sw_val), .change_o(ev[1])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dev
      localparam logic [DBITS-1:0] DATA_ADDR = (gi == 0) ? ADDRKEY : ADDRSW;
      localparam logic [DBITS-1:0] CTRL_ADDR = (gi == 0) ? ADDRKCTRL : ADDRSCTRL;

      dev_status_t st_q, st_d;
      logic        data_ld, ctrl_st;

      assign data_ld = bus.re && (bus.addr == DATA_ADDR);
      assign ctrl_st = bus.we && (bus.addr == CTRL_ADDR);

      // A fresh event outranks both a data load and a software Overrun clear.
      always_comb begin
        st_d = st_q;
        if (ev[gi]) begin
          st_d.ready = 1'b1;
        end else if (data_ld) begin
          st_d.ready = 1'b0;
        end
        if (ctrl_st) begin
          st_d.ie = bus.wdata[CTRL_IE];
          if (!bus.wdata[CTRL_OVERRUN]) begin
            st_d.overrun = 1'b0;
          end
        end
        if (ev[gi] && st_q.ready && !data_ld) begin
          st_d.overrun = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st_q <= '0;
        end else begin
          st_q <= st_d;
        end
      end

      assign irq_src[gi] = st_q.ready & st_q.ie;
      assign ctrl_rd[gi] = ctrl_word(st_q);
    end
  endgenerate

  always_comb begin
    bus.rdata = '0;
    bus.hit   = 1'b1;
    case (bus.addr)
      ADDRKEY:   bus.rdata = {{(DBITS-4){1'b0}}, key_val};
      ADDRSW:    bus.rdata = {{(DBITS-10){1'b0}}, sw_val};
      ADDRKCTRL: bus.rdata = ctrl_rd[0];
      ADDRSCTRL: bus.rdata = ctrl_rd[1];
      default:   bus.hit   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_src;
    end
  end

  assign irq = irq_q;
  assign wdata_unused = ^{bus.wdata[DBITS-1:5], bus.wdata[3], bus.wdata[1:0]};

endmodule

// File: tb/tb_key_sw_io_device.sv
// Directed bench for key_sw_io_device with DEBCYCLES=4 (event 6 edges after a raw change).
module tb_key_sw_io_device;
  import key_sw_io_device_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic       irq;
  int         checks = 0;
  int         failures = 0;

  key_sw_io_device_if bus();

  key_sw_io_device #(.DEBCYCLES(4)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic rd_hit(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_hit);
    rd(tag, a, exp);
    chk({tag, "_hit"}, {31'b0, bus.hit}, {31'b0, exp_hit});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    $display("store addr=0x%08h data=0x%08h", a, d);
    step(1);
    bus.we = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    $display("load  addr=0x%08h data=0x%08h", a, bus.rdata);
    chk(tag, bus.rdata, exp);
    step(1);
    bus.re = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    KEY       = 4'hF;
    SW        = 10'h000;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    step(3);
    reset = 1'b0;

    // Reset state and address decode
    rd_hit("rst_kdata", ADDRKEY, 32'h0, 1'b1);
    rd_hit("rst_sdata", ADDRSW, 32'h0, 1'b1);
    rd_hit("rst_kctrl", ADDRKCTRL, 32'h0, 1'b1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    step(1);
    rd_hit("nohit", 32'hF000_0018, 32'h0, 1'b0);
    rd_hit("rst_sctrl", ADDRSCTRL, 32'h0, 1'b1);

    // Short glitch is rejected, then a held press lands after exactly 6 edges
    KEY = 4'hD;
    step(3);
    KEY = 4'hF;
    step(10);
    rd("glitch_kdata", ADDRKEY, 32'h0);
    rd("glitch_kctrl", ADDRKCTRL, 32'h0);
    KEY = 4'hE;
    step(5);
    rd("lat5_kdata", ADDRKEY, 32'h0);
    step(1);
    rd("lat6_kdata", ADDRKEY, 32'h1);
    rd("lat6_kctrl", ADDRKCTRL, 32'h1);

    // Interrupt enable, Ready clear on data load
    load("k_load1", ADDRKEY, 32'h1);
    rd("k_ready_clr", ADDRKCTRL, 32'h0);
    store(ADDRKCTRL, 32'h11);
    rd("k_ie_only", ADDRKCTRL, 32'h10);
    chk("irq_idle", {31'b0, irq}, 32'h0);
    KEY = 4'hC;
    step(6);
    rd("k_press2", ADDRKEY, 32'h3);
    rd("k_ready_ie", ADDRKCTRL, 32'h11);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    step(1);
    chk("irq_set", {31'b0, irq}, 32'h1);
    load("k_load2", ADDRKEY, 32'h3);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    rd("k_ready_clr2", ADDRKCTRL, 32'h10);
    step(1);
    chk("irq_clr", {31'b0, irq}, 32'h0);

    // SW overrun and software clear
    SW = 10'h3FF;
    step(6);
    rd("s_data1", ADDRSW, 32'h3FF);
    rd("s_ready", ADDRSCTRL, 32'h1);
    SW = 10'h155;
    step(6);
    rd("s_data2", ADDRSW, 32'h155);
    rd("s_overrun", ADDRSCTRL, 32'h5);
    chk("irq_sie0", {31'b0, irq}, 32'h0);
    store(ADDRSCTRL, 32'h0);
    rd("s_ovr_clr", ADDRSCTRL, 32'h1);
    load("s_load", ADDRSW, 32'h155);
    rd("s_ready_clr", ADDRSCTRL, 32'h0);

    // Load coincident with an event: Ready stays, no Overrun
    KEY = 4'hE;
    step(6);
    rd("k_ready3", ADDRKCTRL, 32'h11);
    KEY = 4'hF;
    step(5);
    rd("k_pre_ev", ADDRKEY, 32'h1);
    load("k_load_ev", ADDRKEY, 32'h1);
    rd("k_ld_ev_ctrl", ADDRKCTRL, 32'h11);
    rd("k_ld_ev_data", ADDRKEY, 32'h0);

    // Overrun clear coincident with an overrun event: the set wins
    KEY = 4'hE;
    step(5);
    store(ADDRKCTRL, 32'h10);
    rd("k_set_wins", ADDRKCTRL, 32'h15);
    store(ADDRKCTRL, 32'h14);
    rd("k_ovr_keep", ADDRKCTRL, 32'h15);
    store(ADDRKCTRL, 32'h10);
    rd("k_ovr_clr", ADDRKCTRL, 32'h11);
    bus.addr  = ADDRKCTRL;
    bus.wdata = 32'h0;
    bus.we    = 1'b1;
    bus.re    = 1'b1;
    #1;
    chk("k_rw_pre", bus.rdata, 32'h11);
    step(1);
    bus.we = 1'b0;
    bus.re = 1'b0;
    rd("k_rw_post", ADDRKCTRL, 32'h1);
    store(ADDRKEY, 32'hFFFF_FFFF);
    rd("k_ro", ADDRKEY, 32'h1);
    store(ADDRKCTRL, 32'h10);
    step(1);
    chk("irq_reen", {31'b0, irq}, 32'h1);

    // Asynchronous reset mid-debounce, then full latency again
    KEY = 4'hB;
    step(5);
    rd("k_mid_deb", ADDRKEY, 32'h1);
    reset = 1'b1;
    rd("arst_kdata", ADDRKEY, 32'h0);
    rd("arst_kctrl", ADDRKCTRL, 32'h0);
    rd("arst_sdata", ADDRSW, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    step(1);
    reset = 1'b0;
    step(5);
    rd("post_rst5", ADDRKEY, 32'h0);
    step(1);
    rd("post_rst6", ADDRKEY, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
